questionnaire_scorer: RTL and testbench
=======================================

// Module: questionnaire_scorer
// PURPOSE
//  Parametrised answer-collection and scoring engine for the diabetes-detector front panel.
//  Operator keys decimal answers on one-hot SW digit keys and commits each with NEXT.
//  After N_Q answers, the block converts the stored BCD answers to binary and accumulates them.
//  It then flags risk against RISK_LIMIT; the top level decodes the BCD/index outputs to HEX5..HEX0.
// PARAMETERS
//  N_Q        8    number of questions (1..2^QW-1)
//  QW         4    width of question index
//  N_DIG      3    max decimal digits per answer (1..4)
//  SUM_W      16   width of score accumulator; must hold N_Q*(10^N_DIG-1)
//  RISK_LIMIT 500  RISK=1 when SUM >= RISK_LIMIT
// PORTS
//  ADC_CLK_10  in   1          system clock, all logic on rising edge
//  RST_N       in   1          asynchronous active-low reset
//  SW          in   10         digit keys, SW[d] high = digit d pressed (level, async to logic)
//  NEXT        in   1          commit current answer (level, active high)
//  CLR         in   1          clear entry / restart (level, active high)
//  ENTRY_BCD   out  4*N_DIG    current entry, digit 0 = LSD
//  Q_IDX       out  QW         index of question being answered (0-based)
//  BUSY        out  1          high while in SCORE
//  DONE        out  1          high in DONE state
//  SUM         out  SUM_W      binary sum of all answers (valid when DONE)
//  RISK        out  1          SUM >= RISK_LIMIT (valid when DONE, else 0)
//  OVF         out  1          sticky: digit rejected because entry already had N_DIG digits
// BEHAVIOUR
//  - Reset (async): state=ENTRY, ENTRY_BCD=0, digit count=0, Q_IDX=0, all stored answers=0,
//    SUM=0, BUSY=DONE=RISK=OVF=0.
//  - SW, NEXT, CLR: 2-flop synchroniser, then rising-edge detect (1-cycle pulse).
//    Response is 3 cycles after the input rises.
//  - Digit event: SW-edge vector nonzero AND exactly one bit set; multi-bit edges are ignored.
//  - Priority per cycle: CLR > NEXT > digit. Lower-priority events in the same cycle are dropped.
//  - State ENTRY:
//    . digit d, count<N_DIG: ENTRY_BCD <= {ENTRY_BCD[4*N_DIG-5:0], d}, count++.
//    . digit d, count==N_DIG: entry unchanged, OVF<=1.
//    . NEXT with count==0: ignored (answer required).
//    . NEXT with count>0: store ENTRY_BCD at slot Q_IDX, clear entry/count/OVF.
//      If Q_IDX==N_Q-1, go to SCORE (Q_IDX stays N_Q-1); else Q_IDX++.
//    . CLR: clear entry, count, OVF only. Q_IDX and stored answers are kept.
//  - State SCORE (BUSY=1): SUM cleared on entry. One answer per cycle, slots 0..N_Q-1:
//    SUM += BCD->binary (sum of digit_i*10^i).
//    Exactly N_Q cycles, then DONE. All events ignored except reset.
//  - State DONE (DONE=1): RISK = (SUM >= RISK_LIMIT), registered. Digit/NEXT ignored.
//    CLR restarts: Q_IDX=0, answers=0, SUM=0, RISK=0, return to ENTRY.
//  - SUM does not wrap if SUM_W obeys the rule above. Overflow beyond SUM_W is a misconfiguration.
//  - Reset asserted mid-entry or mid-score aborts immediately to the reset state.
// TESTING
//  - Reset: RST_N=0 with random SW -> all outputs 0, Q_IDX=0, state ENTRY.
//  - Full run with defaults: answers 6,148,72,35,0,37,627,50, each committed by NEXT.
//    -> BUSY for 8 cycles, then DONE=1, SUM=975, RISK=1.
//    Same run with answers 1,1,1,1,1,1,1,1 -> SUM=8, RISK=0.
//  - Overflow: keys 1,2,3,4 -> ENTRY_BCD=0x123, OVF=1.
//    CLR -> ENTRY_BCD=0, OVF=0, Q_IDX unchanged.
//  - Empty commit and multi-key press:
//    NEXT with no digits -> Q_IDX unchanged.
//    SW[2] and SW[5] rising same cycle -> no digit accepted.
//  - Priority: CLR and NEXT rise same cycle after entering 7 -> entry cleared, Q_IDX unchanged.
//    In DONE, NEXT/digits -> no change; CLR -> Q_IDX=0, DONE=0, SUM=0.
//  - Async reset mid-SCORE (cycle 3 of 8) -> BUSY=0, SUM=0, Q_IDX=0 immediately.
//    Next full run still yields SUM=975.

Source files
------------

// File: rtl/questionnaire_scorer.sv
// Answer entry, storage and scoring engine: keyed BCD answers are summed in binary after N_Q commits.
// Key response 3 cycles after a rising input; scoring takes N_Q cycles; no backpressure (level keys).
module questionnaire_scorer #(
   parameter int N_Q        = 8,
   parameter int QW         = 4,
   parameter int N_DIG      = 3,
   parameter int SUM_W      = 16,
   parameter int RISK_LIMIT = 500
) (
   input  logic                 ADC_CLK_10,
   input  logic                 RST_N,
   input  logic [9:0]           SW,
   input  logic                 NEXT,
   input  logic                 CLR,
   output logic [4*N_DIG-1:0]   ENTRY_BCD,
   output logic [QW-1:0]        Q_IDX,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [SUM_W-1:0]     SUM,
   output logic                 RISK,
   output logic                 OVF
);

   localparam int EW = 4 * N_DIG;
   localparam int CW = $clog2(N_DIG + 1);

   typedef enum logic [1:0] {S_ENTRY, S_SCORE, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [11:0]     in_s1, in_s2, in_d;
   logic [11:0]     edges;
   logic [9:0]      sw_edge;
   logic            next_ev, clr_ev, digit_ev;
   logic [3:0]      digit;
   logic [CW-1:0]   cnt;
   logic [QW-1:0]   sc_idx;
   logic [EW-1:0]   ans [N_Q];
   logic [EW-1:0]   cur_bcd;
   logic [SUM_W-1:0] sum_nxt;
   logic            last_q, last_sc;

   function automatic logic [SUM_W-1:0] bcd2bin(input logic [EW-1:0] b);
      logic [SUM_W-1:0] v;
      v = '0;
      for (int i = N_DIG - 1; i >= 0; i--)
         v = v * SUM_W'(10) + SUM_W'(b[4*i +: 4]);
      return v;
   endfunction

   // Two-flop synchroniser followed by a one-cycle rising-edge pulse
   always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
      if (!RST_N) begin
         in_s1 <= '0;
         in_s2 <= '0;
         in_d  <= '0;
      end else begin
         in_s1 <= {CLR, NEXT, SW};
         in_s2 <= in_s1;
         in_d  <= in_s2;
      end
   end

   assign edges    = in_s2 & ~in_d;
   assign sw_edge  = edges[9:0];
   assign next_ev  = edges[10];
   assign clr_ev   = edges[11];
   assign digit_ev = (sw_edge != 10'd0) && ((sw_edge & (sw_edge - 10'd1)) == 10'd0);
   assign last_q   = (Q_IDX == QW'(N_Q - 1));
   assign last_sc  = (sc_idx == QW'(N_Q - 1));

   always_comb begin
      digit   = 4'd0;
      cur_bcd = '0;
      for (int i = 0; i < 10; i++)
         if (sw_edge[i]) digit = 4'(i);
      for (int i = 0; i < N_Q; i++)
         if (sc_idx == QW'(i)) cur_bcd = ans[i];
      sum_nxt = SUM + bcd2bin(cur_bcd);
   end

   always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
      if (!RST_N) state <= S_ENTRY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ENTRY: if (!clr_ev && next_ev && cnt != '0 && last_q) state_nxt = S_SCORE;
         S_SCORE: if (last_sc) state_nxt = S_DONE;
         S_DONE:  if (clr_ev) state_nxt = S_ENTRY;
         default: state_nxt = S_ENTRY;
      endcase
   end

   assign BUSY = (state == S_SCORE);
   assign DONE = (state == S_DONE);

   always_ff @(posedge ADC_CLK_10 or negedge RST_N) begin
      if (!RST_N) begin
         ENTRY_BCD <= '0;
         cnt       <= '0;
         OVF       <= 1'b0;
         Q_IDX     <= '0;
         sc_idx    <= '0;
         SUM       <= '0;
         RISK      <= 1'b0;
         for (int i = 0; i < N_Q; i++) ans[i] <= '0;
      end else begin
         case (state)
            S_ENTRY: begin
               if (clr_ev) begin
                  ENTRY_BCD <= '0;
                  cnt       <= '0;
                  OVF       <= 1'b0;
               end else if (next_ev) begin
                  if (cnt != '0) begin
                     for (int i = 0; i < N_Q; i++)
                        if (Q_IDX == QW'(i)) ans[i] <= ENTRY_BCD;
                     ENTRY_BCD <= '0;
                     cnt       <= '0;
                     OVF       <= 1'b0;
                     if (last_q) begin
                        SUM    <= '0;
                        sc_idx <= '0;
                     end else begin
                        Q_IDX <= Q_IDX + 1'b1;
                     end
                  end
               end else if (digit_ev) begin
                  if (cnt < CW'(N_DIG)) begin
                     ENTRY_BCD <= (ENTRY_BCD << 4) | EW'(digit);
                     cnt       <= cnt + 1'b1;
                  end else begin
                     OVF <= 1'b1;
                  end
               end
            end
            S_SCORE: begin
               SUM    <= sum_nxt;
               sc_idx <= sc_idx + 1'b1;
               // Risk is registered alongside the final accumulation so it is valid on DONE entry
               if (last_sc) RISK <= (sum_nxt >= SUM_W'(RISK_LIMIT));
            end
            S_DONE: begin
               if (clr_ev) begin
                  Q_IDX     <= '0;
                  SUM       <= '0;
                  RISK      <= 1'b0;
                  ENTRY_BCD <= '0;
                  cnt       <= '0;
                  OVF       <= 1'b0;
                  for (int i = 0; i < N_Q; i++) ans[i] <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_questionnaire_scorer.sv
// Directed bench for questionnaire_scorer with default parameters.
module tb_questionnaire_scorer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [9:0]  sw = '0;
   logic        next = 1'b0;
   logic        clr = 1'b0;
   logic [11:0] entry_bcd;
   logic [3:0]  q_idx;
   logic        busy, done, risk, ovf;
   logic [15:0] sum;

   int total = 0;
   int bad = 0;

   int ans_a [8] = '{6, 148, 72, 35, 0, 37, 627, 50};
   int ans_b [8] = '{1, 1, 1, 1, 1, 1, 1, 1};

   questionnaire_scorer dut (
      .ADC_CLK_10(clk), .RST_N(rst_n), .SW(sw), .NEXT(next), .CLR(clr),
      .ENTRY_BCD(entry_bcd), .Q_IDX(q_idx), .BUSY(busy), .DONE(done),
      .SUM(sum), .RISK(risk), .OVF(ovf)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_sw(input int d);
      @(negedge clk);
      sw[d] = 1'b1;
      tick(4);
      sw = '0;
      tick(4);
   endtask

   task automatic press_next();
      @(negedge clk);
      next = 1'b1;
      tick(4);
      next = 1'b0;
      tick(4);
   endtask

   task automatic press_clr();
      @(negedge clk);
      clr = 1'b1;
      tick(4);
      clr = 1'b0;
      tick(4);
   endtask

   task automatic enter_digits(input int v);
      if (v >= 100) press_sw(v / 100);
      if (v >= 10) press_sw((v / 10) % 10);
      press_sw(v % 10);
   endtask

   task automatic do_reset();
      @(negedge clk);
      sw = '0; next = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_reset();
      #3;
      sw = 10'($urandom);
      rst_n = 1'b0;
      #1;
      total++;
      if ({entry_bcd, q_idx, busy, done, sum, risk, ovf} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got entry=%0h q=%0d busy=%0b done=%0b sum=%0d risk=%0b ovf=%0b want all 0",
                  entry_bcd, q_idx, busy, done, sum, risk, ovf);
      end
      tick(3);
      sw = '0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
      total++;
      if (entry_bcd !== 12'h0 || q_idx !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got entry=%0h q=%0d busy=%0b done=%0b want 0", entry_bcd, q_idx, busy, done);
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      sw[3] = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      total++;
      if (entry_bcd !== 12'h0) begin
         bad++;
         $display("FAIL latency_early: got entry=%0h want 0", entry_bcd);
      end
      @(posedge clk); #1;
      total++;
      if (entry_bcd !== 12'h3) begin
         bad++;
         $display("FAIL latency_third: got entry=%0h want 3", entry_bcd);
      end
      @(negedge clk);
      sw = '0;
      tick(4);
      press_clr();
   endtask

   task automatic test_overflow();
      enter_digits(5);
      press_next();
      total++;
      if (q_idx !== 4'd1) begin
         bad++;
         $display("FAIL commit_idx: got q=%0d want 1", q_idx);
      end
      press_sw(1); press_sw(2); press_sw(3); press_sw(4);
      total++;
      if (entry_bcd !== 12'h123 || ovf !== 1'b1) begin
         bad++;
         $display("FAIL overflow: got entry=%0h ovf=%0b want 123 1", entry_bcd, ovf);
      end
      press_clr();
      total++;
      if (entry_bcd !== 12'h0 || ovf !== 1'b0 || q_idx !== 4'd1) begin
         bad++;
         $display("FAIL clr_entry: got entry=%0h ovf=%0b q=%0d want 0 0 1", entry_bcd, ovf, q_idx);
      end
   endtask

   task automatic test_empty_multikey();
      press_next();
      total++;
      if (q_idx !== 4'd1) begin
         bad++;
         $display("FAIL empty_commit: got q=%0d want 1", q_idx);
      end
      @(negedge clk);
      sw = 10'b00_0010_0100;
      tick(4);
      sw = '0;
      tick(4);
      total++;
      if (entry_bcd !== 12'h0) begin
         bad++;
         $display("FAIL multi_key: got entry=%0h want 0", entry_bcd);
      end
   endtask

   task automatic test_priority();
      press_sw(7);
      total++;
      if (entry_bcd !== 12'h7) begin
         bad++;
         $display("FAIL prio_setup: got entry=%0h want 7", entry_bcd);
      end
      @(negedge clk);
      clr = 1'b1; next = 1'b1;
      tick(4);
      clr = 1'b0; next = 1'b0;
      tick(4);
      total++;
      if (entry_bcd !== 12'h0 || q_idx !== 4'd1) begin
         bad++;
         $display("FAIL clr_over_next: got entry=%0h q=%0d want 0 1", entry_bcd, q_idx);
      end
      press_next();
      total++;
      if (q_idx !== 4'd1) begin
         bad++;
         $display("FAIL clr_cleared_count: got q=%0d want 1", q_idx);
      end
   endtask

   task automatic full_run(input int a [8], input int exp_sum, input logic exp_risk);
      int busy_cnt;
      bit seen_done;
      for (int i = 0; i < 7; i++) begin
         enter_digits(a[i]);
         press_next();
      end
      enter_digits(a[7]);
      @(negedge clk);
      next = 1'b1;
      busy_cnt = 0;
      seen_done = 0;
      for (int c = 0; c < 30 && !seen_done; c++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) seen_done = 1;
      end
      next = 1'b0;
      tick(4);
      total++;
      if (!seen_done || busy_cnt != 8) begin
         bad++;
         $display("FAIL run_busy: got done_seen=%0b busy_cycles=%0d want 1 8", seen_done, busy_cnt);
      end
      total++;
      if (sum !== 16'(exp_sum) || risk !== exp_risk || done !== 1'b1 || q_idx !== 4'd7) begin
         bad++;
         $display("FAIL run_result: got sum=%0d risk=%0b done=%0b q=%0d want %0d %0b 1 7",
                  sum, risk, done, q_idx, exp_sum, exp_risk);
      end
   endtask

   task automatic test_done_state();
      press_next();
      press_sw(4);
      total++;
      if (done !== 1'b1 || sum !== 16'd8 || entry_bcd !== 12'h0 || q_idx !== 4'd7) begin
         bad++;
         $display("FAIL done_ignore: got done=%0b sum=%0d entry=%0h q=%0d want 1 8 0 7", done, sum, entry_bcd, q_idx);
      end
      press_clr();
      total++;
      if (done !== 1'b0 || sum !== 16'd0 || q_idx !== 4'd0 || risk !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_restart: got done=%0b sum=%0d q=%0d risk=%0b busy=%0b want 0 0 0 0 0",
                  done, sum, q_idx, risk, busy);
      end
   endtask

   task automatic test_score_reset();
      bit seen_busy;
      for (int i = 0; i < 7; i++) begin
         enter_digits(ans_a[i]);
         press_next();
      end
      enter_digits(ans_a[7]);
      @(negedge clk);
      next = 1'b1;
      seen_busy = 0;
      for (int c = 0; c < 20 && !seen_busy; c++) begin
         @(negedge clk);
         if (busy) seen_busy = 1;
      end
      tick(2);
      total++;
      if (!seen_busy || sum !== 16'd154) begin
         bad++;
         $display("FAIL score_partial: got busy_seen=%0b sum=%0d want 1 154", seen_busy, sum);
      end
      #2;
      rst_n = 1'b0;
      next = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || sum !== 16'd0 || q_idx !== 4'd0 || done !== 1'b0) begin
         bad++;
         $display("FAIL score_abort: got busy=%0b sum=%0d q=%0d done=%0b want 0 0 0 0", busy, sum, q_idx, done);
      end
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_latency();
      test_overflow();
      test_empty_multikey();
      test_priority();
      do_reset();
      full_run(ans_a, 975, 1'b1);
      do_reset();
      full_run(ans_b, 8, 1'b0);
      test_done_state();
      test_score_reset();
      full_run(ans_a, 975, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
